// File: rtl/ibex_rvfi_trace_buf.sv
// rtl/ibex_rvfi_trace_buf.sv - RVFI retirement trace capture buffer with word-stream drain
// IBEX_TRACE_BUF_TSTAMP_EN adds a free-running cycle stamp as a fifth record word.
module ibex_rvfi_trace_buf #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned DropCntW = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    arm_i,
  input  logic                    clear_i,
  input  logic                    mode_i,
  input  logic                    trig_on_trap_i,
  input  logic                    trig_i,
  input  logic [7:0]              post_cnt_i,
  input  logic                    rvfi_valid_i,
  input  logic [63:0]             rvfi_order_i,
  input  logic [31:0]             rvfi_insn_i,
  input  logic                    rvfi_trap_i,
  input  logic                    rvfi_intr_i,
  input  logic [1:0]              rvfi_mode_i,
  input  logic [31:0]             rvfi_pc_rdata_i,
  input  logic [4:0]              rvfi_rd_addr_i,
  input  logic [31:0]             rvfi_rd_wdata_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [31:0]             rd_data_o,
  output logic                    rd_last_o,
  output logic [1:0]              state_o,
  output logic [$clog2(Depth):0]  count_o,
  output logic [DropCntW-1:0]     drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
`ifdef IBEX_TRACE_BUF_TSTAMP_EN
  localparam int unsigned NumWords = 5;
`else
  localparam int unsigned NumWords = 4;
`endif
  localparam logic [2:0] LastWord = 3'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StFrozen} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [DropCntW-1:0] drop_q;
  logic [7:0]          post_q;
  logic [2:0]          widx_q;

  logic [31:0] mem_pc    [Depth];
  logic [31:0] mem_insn  [Depth];
  logic [31:0] mem_wdata [Depth];
  logic [31:0] mem_meta  [Depth];

  logic unused_order;
  assign unused_order = ^rvfi_order_i[63:16];

  logic capture, full, trigger, beat, last_word;

  assign capture   = (state_q == StArmed || state_q == StPost) && rvfi_valid_i && !clear_i;
  assign full      = (count_q == CntW'(Depth));
  // Only WRAP mode in ARMED reacts to triggers; POST ignores further ones.
  assign trigger   = (state_q == StArmed) && mode_i &&
                     (trig_i || (trig_on_trap_i && rvfi_valid_i && rvfi_trap_i));
  assign last_word = (widx_q == LastWord);
  assign rd_valid_o = (state_q == StFrozen) && (count_q != '0);
  assign rd_last_o  = rd_valid_o && last_word;
  assign beat       = rd_valid_o && rd_ready_i && !clear_i;

  assign state_o    = state_q;
  assign count_o    = count_q;
  assign drop_cnt_o = drop_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (arm_i) state_d = StArmed;
        StArmed: begin
          if (!mode_i) begin
            if (capture && count_q == CntW'(Depth - 1)) state_d = StFrozen;
          end else if (trigger) begin
            state_d = (post_cnt_i == 8'd0) ? StFrozen : StPost;
          end
        end
        StPost:   if (capture && post_q == 8'd1) state_d = StFrozen;
        StFrozen: if (beat && last_word && count_q == CntW'(1)) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      post_q   <= '0;
      widx_q   <= '0;
    end else begin
      if (state_q == StIdle && arm_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= '0;
      end
      if (capture) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        // A full buffer sacrifices its oldest record to keep the newest.
        if (full) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
          if (drop_q != {DropCntW{1'b1}}) drop_q <= drop_q + DropCntW'(1);
        end else begin
          count_q <= count_q + CntW'(1);
        end
      end
      if (trigger)                         post_q <= post_cnt_i;
      else if (state_q == StPost && capture) post_q <= post_q - 8'd1;
      if (beat) begin
        if (last_word) begin
          widx_q   <= '0;
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
          count_q  <= count_q - CntW'(1);
        end else begin
          widx_q <= widx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && capture) begin
      mem_pc[wr_ptr_q]    <= rvfi_pc_rdata_i;
      mem_insn[wr_ptr_q]  <= rvfi_insn_i;
      mem_wdata[wr_ptr_q] <= rvfi_rd_wdata_i;
      mem_meta[wr_ptr_q]  <= {rvfi_order_i[15:0], rvfi_trap_i, rvfi_intr_i, rvfi_mode_i,
                              7'b0, rvfi_rd_addr_i};
    end
  end

`ifdef IBEX_TRACE_BUF_TSTAMP_EN
  logic [31:0] tstamp_q;
  logic [31:0] mem_ts [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) tstamp_q <= '0;
    else         tstamp_q <= tstamp_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && capture) mem_ts[wr_ptr_q] <= tstamp_q;
  end
`endif

  always_comb begin
    rd_data_o = '0;
    if (rd_valid_o) begin
      case (widx_q)
        3'd0:    rd_data_o = mem_pc[rd_ptr_q];
        3'd1:    rd_data_o = mem_insn[rd_ptr_q];
        3'd2:    rd_data_o = mem_wdata[rd_ptr_q];
        3'd3:    rd_data_o = mem_meta[rd_ptr_q];
`ifdef IBEX_TRACE_BUF_TSTAMP_EN
        3'd4:    rd_data_o = mem_ts[rd_ptr_q];
`endif
        default: rd_data_o = '0;
      endcase
    end
  end

endmodule

// File: doc/ibex_rvfi_trace_buf.md
Name: ibex_rvfi_trace_buf

Overview:
- Parametrised on-chip trace capture buffer for retired-instruction records from the core's RVFI port.
- Sits beside the traced core top and taps the same RVFI signals the simulation tracer consumes, so traces also work in synthesised builds.
- Each retirement is packed into a record and stored in a circular buffer with one-shot or wrap/trigger modes.
- Captured records are drained over a 32-bit valid/ready word stream.

Parameters:
- Depth, 16, record slots; power of 2, range 4..256.
- DropCntW, 16, width of the saturating dropped-record counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous active-low
- arm_i  in  1  one-cycle pulse; starts capture from IDLE
- clear_i  in  1  synchronous flush to IDLE
- mode_i  in  1  0 = ONESHOT, 1 = WRAP
- trig_on_trap_i  in  1  in WRAP, a retired record with trap=1 acts as trigger
- trig_i  in  1  external trigger pulse
- post_cnt_i  in  8  records captured after the trigger record
- rvfi_valid_i  in  1  retirement strobe
- rvfi_order_i  in  64  retirement order
- rvfi_insn_i  in  32  instruction
- rvfi_trap_i  in  1  trap flag
- rvfi_intr_i  in  1  interrupt flag
- rvfi_mode_i  in  2  privilege mode
- rvfi_pc_rdata_i  in  32  PC
- rvfi_rd_addr_i  in  5  destination register
- rvfi_rd_wdata_i  in  32  destination data
- rd_valid_o  out  1  drain word valid
- rd_ready_i  in  1  drain word accepted
- rd_data_o  out  32  drain word
- rd_last_o  out  1  last word of a record
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
- count_o  out  $clog2(Depth)+1  records held
- drop_cnt_o  out  DropCntW  records overwritten in WRAP

Behaviour:
- Interface (decided): one clock, clk_i; reset rst_ni is synchronous and active-low.
- Reset: state IDLE, pointers 0, count_o 0, drop_cnt_o 0, rd_valid_o 0, rd_last_o 0, rd_data_o 0, post counter 0, word index 0. Reset asserted mid-drain or mid-capture discards everything.
- Record words, in drain order:
  - W0 = pc
  - W1 = insn
  - W2 = rd_wdata
  - W3 = {order[15:0], trap, intr, mode[1:0], 7'b0, rd_addr}
- Capture:
  - Occurs only in ARMED or POST when rvfi_valid_i=1.
  - The record is written at wr_ptr on the same clock edge and is visible in count_o the next cycle (1-cycle latency).
  - Pointers wrap modulo Depth.
- IDLE:
  - arm_i=1 -> ARMED; buffer is emptied and drop_cnt_o is zeroed on entry.
  - arm_i is ignored in every other state.
- ARMED, ONESHOT (mode_i=0):
  - Captures until count reaches Depth.
  - The cycle the Depth-th record is written -> FROZEN.
  - Triggers are ignored.
- ARMED, WRAP (mode_i=1):
  - Capture while full overwrites the oldest record: rd_ptr advances, count stays Depth, drop_cnt_o increments and saturates at all-ones.
  - Trigger = trig_i, or (trig_on_trap_i && rvfi_valid_i && rvfi_trap_i).
  - On trigger, the trigger record (if any) is stored first, the post counter is loaded with post_cnt_i, and the state goes to POST. If post_cnt_i=0 the state goes directly to FROZEN.
- POST:
  - Each captured record decrements the post counter; when it reaches 0 -> FROZEN.
  - Further triggers are ignored.
  - Overwrite rules are the same as in WRAP.
- FROZEN:
  - No capture.
  - rd_valid_o = (count_o != 0); rd_data_o = word[word_idx] of the record at rd_ptr (combinational from the flop array).
  - A beat transfers when rd_valid_o && rd_ready_i; word_idx then increments.
  - rd_last_o = rd_valid_o && (word_idx == last word). On a last-word transfer: word_idx returns to 0, rd_ptr advances, count decrements.
  - When count reaches 0 after a transfer -> IDLE.
  - rd_data_o must stay stable while rd_valid_o && !rd_ready_i.
- clear_i takes priority over arm_i, capture, trigger and drain. Next cycle: IDLE, empty, drop_cnt_o 0.
- mode_i and trig_on_trap_i are sampled every cycle. Software must hold them stable while armed.

Optional Feature:
- Macro: IBEX_TRACE_BUF_TSTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter is added; it resets to 0 and wraps.
  - The counter value is captured with each record as W4, so records are 5 words and rd_last_o flags W4.
- When undefined: no counter, 4-word records, and no added area.

Test Plan:
- ONESHOT, Depth=16: arm, then 20 retirements with pc=0x100+4n -> FROZEN after the 16th; count_o=16; drain yields 64 words, W0 of the first record = 0x100, last record pc = 0x13C; state IDLE after the final rd_last_o.
- WRAP, post_cnt_i=2: 30 retirements with a trap at n=25 and trig_on_trap_i=1 -> FROZEN after n=27; drop_cnt_o=12; drained pcs cover n=12..27.
- Drain backpressure: hold rd_ready_i=0 for 5 cycles mid-record -> rd_data_o stable throughout; no word lost or duplicated.
- clear_i asserted in the same cycle as rvfi_valid_i and trig_i in POST -> next cycle IDLE, count_o=0, drop_cnt_o=0, nothing captured.
- Reset (rst_ni=0 for 1 cycle) during FROZEN with count_o=7 -> all outputs 0, state IDLE; arm_i one cycle later is accepted.
- With IBEX_TRACE_BUF_TSTAMP_EN: retirements at cycles 10 and 13 after reset -> W4 values differ by 3; rd_last_o is asserted on W4.
